// File: rtl/vc_merge_arbiter.sv
// Four-to-one round-robin merge of the per-class virtual-channel FIFOs into the
// single downstream FIFO toward the link, with per-source grant counters.
module vc_merge_arbiter #(
   parameter int DATA_WIDTH = 12,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_0,
   input  logic                  empty_1,
   input  logic                  empty_2,
   input  logic                  empty_3,
   input  logic [DATA_WIDTH-1:0] data_in_0,
   input  logic [DATA_WIDTH-1:0] data_in_1,
   input  logic [DATA_WIDTH-1:0] data_in_2,
   input  logic [DATA_WIDTH-1:0] data_in_3,
   input  logic                  almost_full,
   output logic                  pop_0,
   output logic                  pop_1,
   output logic                  pop_2,
   output logic                  pop_3,
   output logic                  push,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  idle,
   output logic [CNT_WIDTH-1:0]  count_0,
   output logic [CNT_WIDTH-1:0]  count_1,
   output logic [CNT_WIDTH-1:0]  count_2,
   output logic [CNT_WIDTH-1:0]  count_3
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   state_t                  state_q, state_d;
   logic [1:0]              last_grant_q;
   logic                    push_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [CNT_WIDTH-1:0]    cnt_q [4];

   logic [3:0]              empty_v;
   logic [DATA_WIDTH-1:0]   din_v [4];
   logic                    any_valid;
   logic                    grant;
   logic [1:0]              winner;
   logic [3:0]              pop_v;

   assign empty_v   = {empty_3, empty_2, empty_1, empty_0};
   assign din_v[0]  = data_in_0;
   assign din_v[1]  = data_in_1;
   assign din_v[2]  = data_in_2;
   assign din_v[3]  = data_in_3;
   assign any_valid = ~&empty_v;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_RESET;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_IDLE;
         ST_IDLE:   if (any_valid)  state_d = ST_ACTIVE;
         ST_ACTIVE: if (!any_valid) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      idle = (state_q == ST_IDLE);
   end

   // Search downward so the lowest rotation offset past last_grant_q wins last.
   always_comb begin
      grant  = 1'b0;
      winner = last_grant_q;
      if (!reset && !almost_full && any_valid &&
          (state_q == ST_IDLE || state_q == ST_ACTIVE)) begin
         grant = 1'b1;
         for (int k = 4; k >= 1; k--) begin
            if (!empty_v[last_grant_q + 2'(k)]) winner = last_grant_q + 2'(k);
         end
      end
   end

   always_comb begin
      pop_v = '0;
      if (grant) pop_v[winner] = 1'b1;
   end

   assign {pop_3, pop_2, pop_1, pop_0} = pop_v;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         push_q       <= 1'b0;
         data_q       <= '0;
         last_grant_q <= 2'd3;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         push_q <= grant;
         if (grant) begin
            data_q        <= din_v[winner];
            last_grant_q  <= winner;
            cnt_q[winner] <= cnt_q[winner] + CNT_ONE;
         end
      end
   end

   assign push     = push_q;
   assign data_out = data_q;
   assign count_0  = cnt_q[0];
   assign count_1  = cnt_q[1];
   assign count_2  = cnt_q[2];
   assign count_3  = cnt_q[3];

endmodule
